jt6295_cmdq: RTL

JT6295_CMDQ -- requirements
Module: jt6295_cmdq

---
 rtl/jt6295_pkg.sv | 24 ++
 rtl/jt6295_cmdq_fifo.sv | 58 +++++
 rtl/jt6295_cmdq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/jt6295_pkg.sv
// Shared definitions for the jt6295 command queue: FSM encoding and command byte fields.
package jt6295_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_STROBE = 3'd2,
      ST_GAP    = 3'd3
`ifdef JT6295_CMDQ_BUSYWAIT_EN
      ,
      ST_HOLD   = 3'd4
`endif
   } state_t;

   localparam int PHRASE_BIT = 7;
   localparam int CH_HI      = 7;
   localparam int CH_LO      = 4;

   // A byte issued in phase 0 with the phrase bit set opens a two-byte command
   function automatic logic is_phrase(input logic [7:0] b);
      return b[PHRASE_BIT];
   endfunction

endpackage

// File: rtl/jt6295_cmdq_fifo.sv
// Byte FIFO for the jt6295 command queue: dual pointers, occupancy count, full/empty/drop.
module jt6295_cmdq_fifo #(
   parameter int AW = 3
) (
   input  logic          rst,
   input  logic          clk,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          drop
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

   logic [7:0]    mem [2**AW];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // A pop frees a slot before the push in the same cycle is judged
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;
   assign full    = (count == DEPTH);
   assign empty   = (count == {(AW+1){1'b0}});
   assign rdata   = mem[rd_ptr];

   // Storage array, written on accepted pushes only
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally at 2**AW; count is one bit wider to tell full from empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         count  <= {(AW+1){1'b0}};
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/jt6295_cmdq.sv
// CPU-to-jt6295 write queue: buffers CPU bytes and replays them paced by cen.
// Optional feature: define JT6295_CMDQ_BUSYWAIT_EN to hold channel bytes while the target voices are busy.
module jt6295_cmdq
   import jt6295_pkg::*;
#(
   parameter int AW  = 3,
   parameter int GAP = 4
) (
   input  logic       rst,
   input  logic       clk,
   input  logic       cen,
   input  logic       cpu_wrn,
   input  logic [7:0] cpu_din,
   input  logic [3:0] busy_in,
   output logic       wrn,
   output logic [7:0] din,
   output logic       full,
   output logic       empty,
   output logic       ovf,
   input  logic       ovf_clr
);

   // The IDLE cycle that follows GAP is one of the GAP idle cen cycles
   localparam logic [7:0] GAP_LAST = (GAP >= 2) ? 8'(GAP - 2) : 8'd0;

   state_t      state;
   logic [7:0]  gap_cnt;
   logic        phase;
   logic        cpu_wrn_l;
   logic        push;
   logic        pop;
   logic        drop;
   logic [7:0]  q;
   logic [AW:0] count;

   assign push = ~cpu_wrn & cpu_wrn_l;
   assign pop  = cen & (state == ST_LOAD);

`ifndef JT6295_CMDQ_BUSYWAIT_EN
   logic unused_busy;
   assign unused_busy = ^busy_in;
`endif

   jt6295_cmdq_fifo #(.AW(AW)) u_fifo (
      .rst   (rst),
      .clk   (clk),
      .push  (push),
      .pop   (pop),
      .wdata (cpu_din),
      .rdata (q),
      .count (count),
      .full  (full),
      .empty (empty),
      .drop  (drop)
   );

   // CPU strobe edge detector and sticky overflow (a drop beats a clear)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_wrn_l <= 1'b1;
         ovf       <= 1'b0;
      end else begin
         cpu_wrn_l <= cpu_wrn;
         if (drop) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
      end
   end

   // Issue FSM: pops, strobes and paces bytes towards the chip on cen cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         wrn     <= 1'b1;
         din     <= 8'd0;
         phase   <= 1'b0;
         gap_cnt <= 8'd0;
      end else if (cen) begin
         case (state)
            ST_IDLE: begin
               if (!empty) state <= ST_LOAD;
            end
            ST_LOAD: begin
               din   <= q;
               phase <= phase ? 1'b0 : is_phrase(q);
`ifdef JT6295_CMDQ_BUSYWAIT_EN
               if (phase && ((q[CH_HI:CH_LO] & busy_in) != 4'd0)) begin
                  state <= ST_HOLD;
               end else begin
                  wrn   <= 1'b0;
                  state <= ST_STROBE;
               end
`else
               wrn   <= 1'b0;
               state <= ST_STROBE;
`endif
            end
            ST_STROBE: begin
               wrn     <= 1'b1;
               gap_cnt <= 8'd0;
               state   <= ST_GAP;
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 8'd1;
               end
            end
`ifdef JT6295_CMDQ_BUSYWAIT_EN
            ST_HOLD: begin
               if ((din[CH_HI:CH_LO] & busy_in) == 4'd0) begin
                  wrn   <= 1'b0;
                  state <= ST_STROBE;
               end
            end
`endif
            default: begin
               wrn   <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
